// File: rtl/im_pkg.sv
// im_pkg: shared constants and enums for the instruction-memory arbiter.
//   IM_BASE  - byte address of instruction RAM word 0 (MIPS text base)
//   IM_DEPTH - RAM depth in 32-bit words (power of two)
//   IM_AW    - word index width, log2(IM_DEPTH)
//   req_e    - requester identity (fetch stage / program loader)
//   state_e  - arbiter top-level state
package im_pkg;

  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_DEPTH = 4096;
  localparam int unsigned IM_AW    = 12;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/im_arbiter_if.sv
// im_arbiter_if: bundles the fetch port, loader port, RAM macro port and the
// busy flag of im_arbiter.
//   slave  - arbiter view: takes requests and ram_rdata, drives grants,
//            responses, the RAM command and busy
//   master - requester/RAM side view (fetch stage, loader, RAM macro)
interface im_arbiter_if #(
  parameter int unsigned AW = im_pkg::IM_AW
);

  // fetch stage (read-only)
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;

  // program loader / debug port
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;

  // single-ported synchronous RAM macro
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic          busy;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata, f_err,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );

endinterface

// File: rtl/im_addr_map.sv
// im_addr_map: combinational MIPS byte address -> RAM word index decode.
//   addr - byte address
//   ok   - word aligned and inside [BASE, BASE + 4*DEPTH)
//   idx  - word index (addr - BASE) / 4, meaningful only when ok
module im_addr_map #(
  parameter logic [31:0] BASE  = im_pkg::IM_BASE,
  parameter int unsigned DEPTH = im_pkg::IM_DEPTH,
  parameter int unsigned AW    = im_pkg::IM_AW
) (
  input  logic [31:0]   addr,
  output logic          ok,
  output logic [AW-1:0] idx
);

  // 33-bit bounds so a region ending at the top of the address space cannot wrap
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = {1'b0, BASE} + (33'(DEPTH) << 2);

  logic [32:0] a33;

  assign a33 = {1'b0, addr};
  assign ok  = (addr[1:0] == 2'b00) && (a33 >= LO) && (a33 < HI);
  assign idx = AW'((addr - BASE) >> 2);

endmodule

// File: rtl/im_arbiter.sv
// im_arbiter: shares the single-ported instruction RAM between the fetch stage
// (read-only) and the program loader (read/write).
//   clk, reset - clock, asynchronous active-high reset
//   bus        - im_arbiter_if.slave: fetch and loader req/gnt/response ports,
//                RAM command/read-data port, busy
// After every reset the RAM is zero-filled (DEPTH cycles, busy=1) before any
// grant. Grants are combinational, round-robin under contention; responses
// arrive exactly one cycle after the grant.
module im_arbiter
  import im_pkg::*;
#(
  parameter logic [31:0] BASE  = IM_BASE,
  parameter int unsigned DEPTH = IM_DEPTH,
  parameter int unsigned AW    = IM_AW
) (
  input logic         clk,
  input logic         reset,
  im_arbiter_if.slave bus
);

  localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);

  state_e        state;
  logic [AW:0]   clr_cnt;
  req_e          rr_last;
  logic          rsp_valid;
  req_e          rsp_owner;
  logic          rsp_err;
  logic          rsp_rd;

  logic          f_ok;
  logic [AW-1:0] f_idx;
  logic          l_ok;
  logic [AW-1:0] l_idx;
  logic          run;
  logic          f_win;
  logic          l_win;
  logic          f_rsp;
  logic          l_rsp;

  im_addr_map #(.BASE(BASE), .DEPTH(DEPTH), .AW(AW)) u_fmap (
    .addr (bus.f_addr),
    .ok   (f_ok),
    .idx  (f_idx)
  );

  im_addr_map #(.BASE(BASE), .DEPTH(DEPTH), .AW(AW)) u_lmap (
    .addr (bus.l_addr),
    .ok   (l_ok),
    .idx  (l_idx)
  );

  assign run = (state == ST_RUN);

  // The requester opposite rr_last wins a contention; grants never depend on gnt.
  assign f_win = run && bus.f_req && (!bus.l_req || (rr_last == REQ_LOAD));
  assign l_win = run && bus.l_req && (!bus.f_req || (rr_last == REQ_FETCH));

  assign bus.f_gnt = f_win;
  assign bus.l_gnt = l_win;
  assign bus.busy  = !run;

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    // Clear writes are gated by reset so the RAM stays idle while reset is held.
    if ((state == ST_CLEAR) && !reset) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = 1'b1;
      bus.ram_addr = clr_cnt[AW-1:0];
    end else if (f_win && f_ok) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = f_idx;
      bus.ram_wdata = bus.l_wdata;
    end else if (l_win && l_ok) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.l_we;
      bus.ram_addr  = l_idx;
      bus.ram_wdata = bus.l_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      rr_last   <= REQ_LOAD;
      rsp_valid <= 1'b0;
      rsp_owner <= REQ_FETCH;
      rsp_err   <= 1'b0;
      rsp_rd    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          rsp_valid <= 1'b0;
          clr_cnt   <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          rsp_valid <= f_win || l_win;
          if (f_win) begin
            rr_last   <= REQ_FETCH;
            rsp_owner <= REQ_FETCH;
            rsp_err   <= !f_ok;
            rsp_rd    <= f_ok;
          end else if (l_win) begin
            rr_last   <= REQ_LOAD;
            rsp_owner <= REQ_LOAD;
            rsp_err   <= !l_ok;
            rsp_rd    <= l_ok && !bus.l_we;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign f_rsp = rsp_valid && (rsp_owner == REQ_FETCH);
  assign l_rsp = rsp_valid && (rsp_owner == REQ_LOAD);

  assign bus.f_rvalid = f_rsp;
  assign bus.f_err    = f_rsp && rsp_err;
  assign bus.f_rdata  = (f_rsp && rsp_rd) ? bus.ram_rdata : '0;
  assign bus.l_rvalid = l_rsp;
  assign bus.l_err    = l_rsp && rsp_err;
  assign bus.l_rdata  = (l_rsp && rsp_rd) ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: self-checking bench for im_arbiter with a behavioural RAM
// model, a reference arbitration model and a response scoreboard.
module tb_im_arbiter;
  import im_pkg::*;

  typedef struct {
    logic        owner;  // 0 fetch, 1 loader
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic fill;

  int checks = 0;
  int errors = 0;

  rsp_t        sbq[$];
  logic        rr_m;  // 1 = loader granted last
  logic [31:0] exp_mem [IM_DEPTH];
  logic [31:0] mem     [IM_DEPTH];

  always #5 clk = ~clk;

  im_arbiter_if #(.AW(IM_AW)) bus ();

  im_arbiter #(.BASE(IM_BASE), .DEPTH(IM_DEPTH), .AW(IM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // synchronous single-port RAM, read-before-write; fill presets every word
  always @(posedge clk) begin
    if (fill) begin
      for (int unsigned i = 0; i < IM_DEPTH; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  function automatic logic [11:0] addr_idx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'h0000_3000) >> 2;
    return d[11:0];
  endfunction

  // Compare the response owed by the previous cycle (called at negedge).
  task automatic check_rsp();
    rsp_t e;
    logic has;
    logic efv, elv;
    has = (sbq.size() > 0);
    if (has) e = sbq.pop_front();
    efv = has && (e.owner == 1'b0);
    elv = has && (e.owner == 1'b1);
    checks++;
    if (bus.f_rvalid !== efv) begin
      errors++;
      $display("FAIL f_rvalid got %b exp %b t=%0t", bus.f_rvalid, efv, $time);
    end
    checks++;
    if (bus.l_rvalid !== elv) begin
      errors++;
      $display("FAIL l_rvalid got %b exp %b t=%0t", bus.l_rvalid, elv, $time);
    end
    if (efv) begin
      checks++;
      if (bus.f_err !== e.err || bus.f_rdata !== e.data) begin
        errors++;
        $display("FAIL f_rsp got err=%b data=%h exp err=%b data=%h", bus.f_err, bus.f_rdata, e.err, e.data);
      end
    end
    if (elv) begin
      checks++;
      if (bus.l_err !== e.err || bus.l_rdata !== e.data) begin
        errors++;
        $display("FAIL l_rsp got err=%b data=%h exp err=%b data=%h", bus.l_err, bus.l_rdata, e.err, e.data);
      end
    end
  endtask

  // One ST_RUN cycle: entered at posedge+1, leaves at the next posedge+1.
  task automatic cycle(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic lw, input logic [31:0] la, input logic [31:0] ld);
    logic efg, elg, ok;
    logic [11:0] ix;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_we    = lw;
    bus.l_addr  = la;
    bus.l_wdata = ld;
    efg = fr && (!lr || rr_m);
    elg = lr && (!fr || !rr_m);
    @(negedge clk);
    check_rsp();
    checks++;
    if (bus.f_gnt !== efg || bus.l_gnt !== elg) begin
      errors++;
      $display("FAIL gnt got f=%b l=%b exp f=%b l=%b t=%0t", bus.f_gnt, bus.l_gnt, efg, elg, $time);
    end
    if (efg) begin
      ok = addr_ok(fa);
      ix = addr_idx(fa);
      checks++;
      if (ok && (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== ix)) begin
        errors++;
        $display("FAIL f_ram got en=%b we=%b addr=%h exp en=1 we=0 addr=%h", bus.ram_en, bus.ram_we, bus.ram_addr, ix);
      end else if (!ok && bus.ram_en !== 1'b0) begin
        errors++;
        $display("FAIL f_fault_ram_en got %b exp 0 addr=%h", bus.ram_en, fa);
      end
      rr_m = 1'b0;
      sbq.push_back('{owner: 1'b0, err: !ok, data: ok ? exp_mem[ix] : 32'h0});
    end else if (elg) begin
      ok = addr_ok(la);
      ix = addr_idx(la);
      checks++;
      if (ok && (bus.ram_en !== 1'b1 || bus.ram_we !== lw || bus.ram_addr !== ix
                 || (lw && bus.ram_wdata !== ld))) begin
        errors++;
        $display("FAIL l_ram got en=%b we=%b addr=%h wd=%h exp en=1 we=%b addr=%h wd=%h",
                 bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, lw, ix, ld);
      end else if (!ok && bus.ram_en !== 1'b0) begin
        errors++;
        $display("FAIL l_fault_ram_en got %b exp 0 addr=%h", bus.ram_en, la);
      end
      rr_m = 1'b1;
      sbq.push_back('{owner: 1'b1, err: !ok, data: (ok && !lw) ? exp_mem[ix] : 32'h0});
      if (ok && lw) exp_mem[ix] = ld;
    end else begin
      checks++;
      if (bus.ram_en !== 1'b0 || bus.ram_addr !== 12'h0) begin
        errors++;
        $display("FAIL idle_ram got en=%b addr=%h exp en=0 addr=000", bus.ram_en, bus.ram_addr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    int unsigned bad;
    int unsigned nz;
    bus.f_req = 1'b1; bus.f_addr = 32'h3000;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
    reset = 1'b1;
    fill  = 1'b1;
    @(posedge clk);
    #1 fill = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.f_gnt !== 1'b0 || bus.l_gnt !== 1'b0 || bus.ram_en !== 1'b0
        || bus.ram_we !== 1'b0 || bus.ram_addr !== 12'h0 || bus.ram_wdata !== 32'h0
        || bus.f_rvalid !== 1'b0 || bus.l_rvalid !== 1'b0 || bus.f_err !== 1'b0
        || bus.l_err !== 1'b0 || bus.f_rdata !== 32'h0 || bus.l_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b fg=%b en=%b we=%b addr=%h exp busy=1 rest 0",
               bus.busy, bus.f_gnt, bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    rr_m = 1'b1;
    sbq.delete();
    for (int unsigned i = 0; i < IM_DEPTH; i++) exp_mem[i] = 32'h0;
    bad = 0;
    for (int unsigned k = 0; k < IM_DEPTH; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.f_gnt !== 1'b0 || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1
          || bus.ram_addr !== 12'(k) || bus.ram_wdata !== 32'h0 || bus.f_rvalid !== 1'b0) begin
        if (bad == 0)
          $display("FAIL clear_cycle %0d got busy=%b gnt=%b en=%b addr=%h exp busy=1 gnt=0 en=1 addr=%h",
                   k, bus.busy, bus.f_gnt, bus.ram_en, bus.ram_addr, 12'(k));
        bad++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) errors++;
    nz = 0;
    for (int unsigned i = 0; i < IM_DEPTH; i++) if (mem[i] !== 32'h0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL clear_zero got %0d nonzero words exp 0", nz);
    end
    // cycle 4096: first grant
    cycle(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_run got %b exp 0", bus.busy);
    end
    idle();
  endtask

  task automatic test_single_fetch();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h3004, 32'h2408_0005);
    cycle(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
  endtask

  task automatic test_contention();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h3008, 32'hCAFE_F00D);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h3004, 32'h0);
    for (int unsigned i = 0; i < 4; i++)
      cycle(1'b1, 32'h3008, 1'b1, 1'b0, 32'h3004, 32'h0);
    idle();
  endtask

  task automatic test_faults();
    cycle(1'b1, 32'h3002, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h2FFC, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h7000, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h6FFC, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h7000, 32'h1111_2222);
    idle();
  endtask

  task automatic test_exception_region();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h4180, 32'h1234_5678);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h4180;
    bus.l_req  = 1'b0;
    #1;
    checks++;
    if (bus.ram_addr !== 12'h460) begin
      errors++;
      $display("FAIL exc_ram_addr got %h exp 460", bus.ram_addr);
    end
    cycle(1'b1, 32'h4180, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
  endtask

  task automatic test_reset_midop();
    int unsigned bad;
    cycle(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    bus.f_req = 1'b0;
    sbq.delete();
    @(negedge clk);
    checks++;
    if (bus.f_rvalid !== 1'b0 || bus.l_rvalid !== 1'b0 || bus.busy !== 1'b1 || bus.ram_en !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got frv=%b lrv=%b busy=%b en=%b exp 0 0 1 0",
               bus.f_rvalid, bus.l_rvalid, bus.busy, bus.ram_en);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.ram_addr !== 12'(k) || bus.ram_en !== 1'b1 || bus.busy !== 1'b1 || bus.f_rvalid !== 1'b0) begin
        if (bad == 0)
          $display("FAIL midop_clear %0d got addr=%h en=%b busy=%b exp addr=%h en=1 busy=1",
                   k, bus.ram_addr, bus.ram_en, bus.busy, 12'(k));
        bad++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  initial begin
    fill = 1'b0;
    reset = 1'b1;
    bus.ram_rdata = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_faults();
    test_exception_region();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
# im_arbiter

Arbitrates the single-ported, synchronous 4096-word instruction RAM between two requesters: the CPU fetch stage, which is read-only, and the program loader/debug port, which can read and write. After every reset it zero-fills the RAM before granting any access. It translates MIPS byte addresses (text base 0x0000_3000) to word indices and flags misaligned or out-of-range accesses so the fetch stage can raise AdEL. It sits between the F stage / loader and the RAM macro, replacing direct combinational PC indexing.

## Interface
- BASE, 32'h0000_3000: byte address of RAM word 0
- DEPTH, 4096: RAM words; power of two
- AW, 12: log2(DEPTH)
- clk in 1: clock; single clock domain
- reset in 1: asynchronous, active-high reset
- f_req in 1: fetch request
- f_addr in 32: fetch byte address
- f_gnt out 1: fetch request accepted this cycle
- f_rvalid out 1: fetch response valid
- f_rdata out 32: fetch read data
- f_err out 1: fetch address fault
- l_req in 1: loader request
- l_we in 1: loader write (1) / read (0)
- l_addr in 32: loader byte address
- l_wdata in 32: loader write data
- l_gnt, l_rvalid, l_err out 1 each: as fetch
- l_rdata out 32: loader read data
- ram_en, ram_we out 1 each: RAM enable / write enable
- ram_addr out AW: RAM word index
- ram_wdata out 32: RAM write data
- ram_rdata in 32: RAM read data, valid the cycle after ram_en
- busy out 1: clear sequence in progress

## Operation
- States: ST_CLEAR and ST_RUN. Reset enters ST_CLEAR with clr_cnt=0.
- ST_CLEAR: each cycle drives ram_en=1, ram_we=1, ram_addr=clr_cnt, ram_wdata=0, then clr_cnt++. The cycle that writes DEPTH-1 transitions to ST_RUN. f_gnt=l_gnt=0 and busy=1 throughout.
- ST_RUN, busy=0. Each requester's address is decoded as follows:
  - ok = addr[1:0]==0 && addr>=BASE && addr<BASE+4*DEPTH, computed in 33-bit arithmetic with no wrap.
  - idx = (addr-BASE)[AW+1:2].
- Arbitration:
  - With one request, that request is granted.
  - With both requesting, round-robin: the winner is the requester opposite rr_last. rr_last updates on every grant.
  - rr_last resets to LOADER, so fetch wins the first contention.
  - At most one grant per cycle. The loser holds its req and is not granted that cycle.
- Granted with ok=1: ram_en=1, ram_addr=idx, ram_we=l_we (always 0 for fetch), ram_wdata=l_wdata.
- Granted with ok=0: no RAM access (ram_en=0). The slot is still consumed and rr_last still updates.
- Response, exactly one cycle after grant, for the granted requester only:
  - x_rvalid=1 for one cycle.
  - x_err = !ok.
  - x_rdata = ram_rdata for a read with ok=1, otherwise 0. Loader write acks return rdata=0.
- Idle cycles in ST_RUN drive ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.

## Timing
- While reset is asserted and after it:
  - f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, ram_en, ram_we = 0.
  - f_rdata, l_rdata, ram_addr, ram_wdata = 0.
  - busy=1.
- Clear takes exactly DEPTH cycles after reset deassertion. The first grant is possible in cycle DEPTH.
- x_gnt is combinational from x_req, the state and rr_last in the same cycle. No gnt-to-req combinational path is permitted.
- Read latency is 1 cycle (grant in cycle N, rvalid and rdata in N+1). Back-to-back grants to the same requester give one response per cycle.
- Responses cannot be back-pressured; requesters must accept rvalid.
- Reset mid-operation: any pending response is dropped (rvalid stays 0) and the clear sequence restarts at 0.
- Loader write in N, fetch read of the same word in N+1: the fetch returns the new data (RAM write-first is not required, because the accesses fall in different cycles).

## Structure
- Package im_pkg contains:
  - IM_BASE, IM_DEPTH, IM_AW constants.
  - Requester enum REQ_FETCH/REQ_LOAD (used for rr_last and the response owner register).
  - State enum ST_CLEAR/ST_RUN.
- Sub-module im_addr_map is combinational: addr -> ok, idx. It is instantiated once per requester.
- Registers: state, clr_cnt (AW+1 bits), rr_last, rsp_valid, rsp_owner, rsp_err, rsp_rd.
- The RAM macro is external.

## Test plan
- **Reset and clear:** preload the RAM model with 0xFFFF_FFFF, pulse reset, then hold f_req=1 at 0x3000.
  - busy is high and f_gnt=0 for 4096 cycles.
  - All words read back 0.
  - The first f_gnt occurs in cycle 4096.
- **Single fetch:** loader writes 0x2408_0005 at 0x3004. Then fetch 0x3004: f_gnt in N, f_rvalid=1, f_rdata=0x2408_0005, f_err=0 in N+1.
- **Contention:** f_req and l_req (read) both held for 4 cycles.
  - Grants alternate F, L, F, L.
  - Responses go to the correct owners with 1-cycle latency.
- **Address faults:** fetch 0x3002, 0x2FFC and 0x7000 each give f_err=1, f_rdata=0 and no ram_en. Fetch 0x6FFC gives err=0 and idx=0xFFF.
- **Exception handler region:** loader writes 0x1234_5678 at 0x4180. Fetch 0x4180 observes ram_addr=0x460 and data 0x1234_5678.
- **Reset mid-op:** assert reset in the cycle after a grant.
  - No rvalid is produced.
  - busy rises and the clear restarts at index 0.
